// File: rtl/prs_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prs_spi_pkg
// Description : Shared definitions for the pulse-counter SPI master:
//               FSM state encoding, frame-length helper and SPI mode.
// Revision    : 1.0 - initial release
// ============================================================================
package prs_spi_pkg;

    // FSM state encoding
    localparam logic [2:0] c_enc_idle  = 3'd0;
    localparam logic [2:0] c_enc_setup = 3'd1;
    localparam logic [2:0] c_enc_shift = 3'd2;
    localparam logic [2:0] c_enc_hold  = 3'd3;
    localparam logic [2:0] c_enc_done  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_enc_idle,
        ST_SETUP = c_enc_setup,
        ST_SHIFT = c_enc_shift,
        ST_HOLD  = c_enc_hold,
        ST_DONE  = c_enc_done
    } state_t;

    // SPI mode 0: CPOL=0 (SCK idles low), CPHA=0 (sample on rising edge)
    localparam logic [1:0] c_spi_mode = 2'd0;
    localparam logic       c_sck_idle = c_spi_mode[1];

    // Total bits per frame: one full counter snapshot
    function automatic int frame_bits(input int n_counters, input int width);
        return n_counters * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prs_spi_sck_gen.sv
`default_nettype none
// ============================================================================
// Module      : prs_spi_sck_gen
// Description : SCK generator. While i_en is high, SCK toggles every SCK_DIV
//               i_clk cycles. o_rise/o_fall are single-cycle strobes that are
//               high in the cycle whose closing edge drives SCK high/low.
//               While i_en is low SCK is parked at its idle level.
// Ports       : i_clk, i_rst_n (async, active-low), i_en,
//               o_sck (registered), o_rise, o_fall (combinational strobes)
// Revision    : 1.0 - initial release
// ============================================================================
module prs_spi_sck_gen
    import prs_spi_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int                 c_div_w    = $clog2(SCK_DIV + 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCK_DIV - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic               w_half_done;

    assign w_half_done = i_en && (r_div_cnt == c_div_last);
    assign o_rise      = w_half_done && (o_sck == c_sck_idle);
    assign o_fall      = w_half_done && (o_sck != c_sck_idle);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            o_sck     <= c_sck_idle;
        end else if (!i_en) begin
            r_div_cnt <= '0;
            o_sck     <= c_sck_idle;
        end else if (w_half_done) begin
            r_div_cnt <= '0;
            o_sck     <= ~o_sck;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prs_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : prs_spi_master
// Description : SPI master (mode 0, MSB first) that sends the channel-enable
//               command and captures the full counter snapshot in one
//               full-duplex frame.
// Ports       : i_clk, i_rst_n (async, active-low)
//               i_start / i_cmd      : frame request and enable mask
//               o_busy               : frame in progress
//               o_rx_data/o_rx_valid : captured snapshot and update strobe
//               o_sck/o_mosi/i_miso/o_ssel_n : SPI pins
// Options     : PRS_SPI_AUTO_POLL_EN - when defined, a free-running counter
//               launches a frame every POLL_PERIOD cycles while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module prs_spi_master
    import prs_spi_pkg::*;
#(
    parameter int NUMBER_OF_COUNTERS = 16,
    parameter int COUNTERS_WIDTH     = 8,
    parameter int SCK_DIV            = 4,
    parameter int CS_SETUP           = 8,
    parameter int CS_HOLD            = 4,
    parameter int POLL_PERIOD        = 1000
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_start,
    input  logic [NUMBER_OF_COUNTERS-1:0]                i_cmd,
    output logic                                         o_busy,
    output logic [NUMBER_OF_COUNTERS*COUNTERS_WIDTH-1:0] o_rx_data,
    output logic                                         o_rx_valid,
    output logic                                         o_sck,
    output logic                                         o_mosi,
    input  logic                                         i_miso,
    output logic                                         o_ssel_n
);

    localparam int c_fb     = frame_bits(NUMBER_OF_COUNTERS, COUNTERS_WIDTH);
    localparam int c_bit_w  = $clog2(c_fb + 1);
    localparam int c_cs_max = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int c_cs_w   = $clog2(c_cs_max + 1);

    localparam logic [c_bit_w-1:0] c_last_bit   = c_bit_w'(c_fb - 1);
    localparam logic [c_cs_w-1:0]  c_setup_last = c_cs_w'(CS_SETUP - 1);
    localparam logic [c_cs_w-1:0]  c_hold_last  = c_cs_w'(CS_HOLD - 1);

    state_t             r_state;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [c_cs_w-1:0]  r_cs_cnt;
    logic [c_fb-1:0]    r_tx;
    logic [c_fb-1:0]    r_rx;
    logic               w_start_req;
    logic               w_frame_start;
    logic               w_shift_en;
    logic               w_rise;
    logic               w_fall;

`ifdef PRS_SPI_AUTO_POLL_EN
    localparam int                  c_poll_w    = $clog2(POLL_PERIOD + 1);
    localparam logic [c_poll_w-1:0] c_poll_last = c_poll_w'(POLL_PERIOD - 1);

    logic [c_poll_w-1:0] r_poll_cnt;
    logic                w_poll_expired;

    // Saturates once expired so a frame launches as soon as the FSM is idle
    assign w_poll_expired = (r_poll_cnt == c_poll_last);
    assign w_start_req    = i_start | w_poll_expired;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_poll_cnt <= '0;
        end else if (w_frame_start) begin
            r_poll_cnt <= '0;
        end else if (!w_poll_expired) begin
            r_poll_cnt <= r_poll_cnt + 1'b1;
        end
    end
`else
    assign w_start_req = i_start;
`endif

    assign w_frame_start = (r_state == ST_IDLE) && w_start_req;
    assign w_shift_en    = (r_state == ST_SHIFT);

    prs_spi_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_shift_en),
        .o_sck   (o_sck),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_cs_cnt   <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            o_ssel_n   <= 1'b1;
            o_mosi     <= 1'b0;
            o_busy     <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            o_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        // Command occupies the leading bits, zeros follow
                        r_tx      <= c_fb'(i_cmd) << (c_fb - NUMBER_OF_COUNTERS);
                        r_rx      <= '0;
                        r_cs_cnt  <= '0;
                        r_bit_cnt <= '0;
                        o_ssel_n  <= 1'b0;
                        o_busy    <= 1'b1;
                        o_mosi    <= i_cmd[NUMBER_OF_COUNTERS-1];
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cs_cnt == c_setup_last) begin
                        r_cs_cnt <= '0;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_cs_cnt <= r_cs_cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_rise) begin
                        r_rx <= {r_rx[c_fb-2:0], i_miso};
                    end
                    if (w_fall) begin
                        // Last falling edge leaves MOSI alone and ends the shift
                        if (r_bit_cnt == c_last_bit) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= r_tx << 1;
                            o_mosi    <= r_tx[c_fb-2];
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_cs_cnt == c_hold_last) begin
                        r_cs_cnt <= '0;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cs_cnt <= r_cs_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    o_ssel_n   <= 1'b1;
                    o_busy     <= 1'b0;
                    o_mosi     <= 1'b0;
                    o_rx_data  <= r_rx;
                    o_rx_valid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
